// File: rtl/rv32i_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_dmem_responder_if
// Description : Request/response bundle between an RV32I CPU data port and
//               its data-memory responder.
// Revision    : 1.0  initial release
// ============================================================================
interface rv32i_dmem_responder_if;
    // Request channel (CPU -> memory)
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;

    // Response channel (memory -> CPU)
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_dmem_responder
// Description : Single-outstanding RV32I data memory. Accepts one load/store,
//               waits LATENCY cycles, commits/reads the word and holds the
//               response until the CPU takes it. Byte/half/word accesses
//               with sign/zero extension and fault reporting.
// Revision    : 1.0  initial release
// ============================================================================
module rv32i_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rv32i_dmem_responder_if.slave bus
);

    localparam int         c_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;

    // Latched request fields
    logic        r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;

    // Registered response
    logic [31:0] r_rdata;
    logic        r_err;

    // Storage, never touched by reset
    logic [31:0] r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_cur_we;
    logic [31:0]        w_cur_addr;
    logic [2:0]         w_cur_f3;
    logic [31:0]        w_cur_wdata;
    logic               w_bad_f3;
    logic               w_misalign;
    logic               w_oob;
    logic               w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wlane;
    logic [31:0]        w_rword;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_data;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // With LATENCY=1 the access happens on the accept edge itself, so the
    // live bus fields are used there; otherwise the latched copy is used.
    assign w_cur_we    = (r_state == S_IDLE) ? bus.req_we     : r_we;
    assign w_cur_addr  = (r_state == S_IDLE) ? bus.req_addr   : r_addr;
    assign w_cur_f3    = (r_state == S_IDLE) ? bus.req_funct3 : r_funct3;
    assign w_cur_wdata = (r_state == S_IDLE) ? bus.req_wdata  : r_wdata;

    // Next-state selection for the IDLE/WAIT/RESP handshake FSM
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    // Fault classification: bad funct3 for the access type, or misalignment
    always_comb begin
        w_bad_f3   = 1'b0;
        w_misalign = 1'b0;
        case (w_cur_f3)
            3'b000: w_misalign = 1'b0;
            3'b001: w_misalign = w_cur_addr[0];
            3'b010: w_misalign = |w_cur_addr[1:0];
            3'b100,
            3'b101: begin
                w_bad_f3   = w_cur_we;
                w_misalign = w_cur_f3[0] & w_cur_addr[0];
            end
            default: w_bad_f3 = 1'b1;
        endcase
    end

    assign w_oob = ({2'b00, w_cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err = w_bad_f3 | w_misalign | w_oob;
    assign w_idx = w_cur_addr[c_IDX_W+1:2];

    // Byte enables and lane-replicated store data
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = w_cur_wdata;
        case (w_cur_f3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_cur_addr[1:0];
                w_wlane = {4{w_cur_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_cur_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_cur_wdata[15:0]}};
            end
            2'b10: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_rword = r_mem[w_idx];
    assign w_byte  = w_rword[{w_cur_addr[1:0], 3'b000} +: 8];
    assign w_half  = w_cur_addr[1] ? w_rword[31:16] : w_rword[15:0];

    // Load lane extraction with sign or zero extension
    always_comb begin
        w_load_data = 32'h0000_0000;
        case (w_cur_f3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_rword;
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = 32'h0000_0000;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch and latency down-counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0000_0000;
            r_funct3 <= 3'b000;
            r_wdata  <= 32'h0000_0000;
        end else if (w_accept) begin
            r_cnt    <= c_LAT_M1;
            r_we     <= bus.req_we;
            r_addr   <= bus.req_addr;
            r_funct3 <= bus.req_funct3;
            r_wdata  <= bus.req_wdata;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response capture on the edge entering RESP; held until handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_err   <= w_err;
            r_rdata <= (w_cur_we || w_err) ? 32'h0000_0000 : w_load_data;
        end
    end

    // Store commit; gated by rst_n so a reset abandons a pending store
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && w_cur_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rv32i_dmem_responder
// Description : Scoreboard bench for rv32i_dmem_responder. A driver issues
//               directed and random accesses and queues expected responses
//               from a byte-array memory model; a monitor checks them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rv32i_dmem_responder;

    localparam int DEPTH  = 1024;
    localparam int LAT    = 2;
    localparam int PERIOD = 10;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        time         t_acc;
        string       name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    exp_t     q[$];
    int       n_cmp   = 0;
    int       n_fail  = 0;
    int       rr_mode = 0;
    bit [7:0] mb [0:DEPTH*4-1];

    rv32i_dmem_responder_if bus();

    rv32i_dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: byte-addressed little-endian memory
    function automatic void model(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                                  input logic [31:0] wd, output logic [31:0] rd, output bit err);
        int size;
        bit sgn;
        bit bad;
        size = 0;
        sgn  = 1'b0;
        bad  = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: begin size = 1; bad = we; end
            3'd5: begin size = 2; bad = we; end
            default: bad = 1'b1;
        endcase
        err = bad || ((addr / 4) >= DEPTH) || ((size > 0) && ((addr % size) != 0));
        rd  = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) mb[int'(addr) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) rd = rd | (32'(mb[int'(addr) + i]) << (8*i));
            if (sgn && (size < 4) && rd[8*size-1]) rd = rd | ~((32'd1 << (8*size)) - 32'd1);
        end
    endfunction

    task automatic issue(input string nm, input bit we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input bit use_exp, input logic [31:0] xr, input bit xe);
        exp_t        e;
        int          waitc;
        logic [31:0] mr;
        bit          me;
        waitc = 0;
        @(negedge clk);
        while (!bus.req_ready) begin
            waitc++;
            if (waitc > 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s accept: req_ready stuck at 0 expected 1", nm);
                return;
            end
            @(negedge clk);
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_wdata  = wd;
        model(we, addr, f3, wd, mr, me);
        @(posedge clk);
        e.t_acc = $time;
        e.name  = nm;
        e.rdata = use_exp ? xr : mr;
        e.err   = use_exp ? xe : me;
        q.push_back(e);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_funct3 = 3'($urandom);
        bus.req_wdata  = $urandom;
    endtask

    task automatic wait_idle(input string nm);
        int c;
        c = 0;
        while ((q.size() != 0) || !bus.req_ready) begin
            @(posedge clk);
            #2;
            c++;
            if (c > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s idle: pending %0d expected 0", nm, q.size());
                return;
            end
        end
    endtask

    // Response-ready driver: random backpressure, forced low, or forced high
    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       bus.resp_ready = ($urandom_range(0, 2) != 0);
                1:       bus.resp_ready = 1'b0;
                default: bus.resp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops expectations on each new response and checks holding
    initial begin
        logic        pv;
        logic [31:0] prd;
        logic        pe;
        exp_t        e;
        time         te;
        pv  = 1'b0;
        prd = 32'h0;
        pe  = 1'b0;
        forever begin
            @(posedge clk);
            te = $time;
            #1;
            if (pv) begin
                if (bus.resp_ready) begin
                    check("resp_valid after handshake", 32'(bus.resp_valid), 32'd0);
                    check("req_ready after handshake", 32'(bus.req_ready), 32'd1);
                end else begin
                    check("resp_valid held", 32'(bus.resp_valid), 32'd1);
                    check("rdata held", bus.resp_rdata, prd);
                    check("err held", 32'(bus.resp_err), 32'(pe));
                    check("req_ready low in RESP", 32'(bus.req_ready), 32'd0);
                end
            end else if (bus.resp_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected response: got rdata %h expected no response", bus.resp_rdata);
                end else begin
                    e = q.pop_front();
                    check({e.name, " rdata"}, bus.resp_rdata, e.rdata);
                    check({e.name, " err"}, 32'(bus.resp_err), 32'(e.err));
                    check({e.name, " latency"}, 32'((te - e.t_acc) / PERIOD), 32'(LAT));
                end
                prd = bus.resp_rdata;
                pe  = bus.resp_err;
            end
            pv = bus.resp_valid;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus
    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int          r;
        int          c;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_funct3 = 3'b000;
        bus.req_wdata  = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset resp_err", 32'(bus.resp_err), 32'd0);
        check("reset resp_rdata", bus.resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready after reset", 32'(bus.req_ready), 32'd1);

        // Known contents for the region the random phase uses
        for (int w = 0; w < 16; w++) issue("init SW", 1'b1, 32'(w * 4), 3'd2, $urandom, 1'b0, 32'h0, 1'b0);

        issue("SW 0x10", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        issue("LW 0x10 a", 1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        issue("SB 0x11", 1'b1, 32'h11, 3'd0, 32'h80, 1'b1, 32'h0, 1'b0);
        issue("LW 0x10 b", 1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEAD80EF, 1'b0);
        issue("LB 0x11", 1'b0, 32'h11, 3'd0, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
        issue("LBU 0x11", 1'b0, 32'h11, 3'd4, 32'h0, 1'b1, 32'h00000080, 1'b0);
        issue("LH 0x13", 1'b0, 32'h13, 3'd1, 32'h0, 1'b1, 32'h0, 1'b1);
        issue("SW 0x12", 1'b1, 32'h12, 3'd2, 32'h12345678, 1'b1, 32'h0, 1'b1);
        issue("LW 0x10 c", 1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEAD80EF, 1'b0);
        wait_idle("directed");

        // Hold resp_ready low for five cycles of RESP
        @(posedge clk);
        rr_mode = 1;
        issue("LW hold", 1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEAD80EF, 1'b0);
        c = 0;
        while (!bus.resp_valid && (c < 50)) begin
            @(posedge clk);
            #2;
            c++;
        end
        check("hold resp_valid seen", 32'(bus.resp_valid), 32'd1);
        repeat (5) @(posedge clk);
        rr_mode = 2;
        wait_idle("hold");
        rr_mode = 0;

        // Reset during WAIT abandons a store
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h20;
        bus.req_funct3 = 3'd2;
        bus.req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid reset resp_rdata", bus.resp_rdata, 32'd0);
        check("mid reset resp_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("abandoned resp_valid", 32'(bus.resp_valid), 32'd0);
        end
        issue("LW 0x20 after reset", 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 32'h0, 1'b0);

        issue("LW out of range", 1'b0, 32'(DEPTH * 4), 3'd2, 32'h0, 1'b1, 32'h0, 1'b1);
        issue("load f3 011", 1'b0, 32'h10, 3'd3, 32'h0, 1'b1, 32'h0, 1'b1);

        // Random accesses over the initialised region plus faulting addresses
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            else if (r == 1) a = 32'hF000_0000 | $urandom;
            else a = 32'($urandom_range(0, 63));
            wd = $urandom;
            issue("random", 1'($urandom), a, 3'($urandom), wd, 1'b0, 32'h0, 1'b0);
        end
        wait_idle("final");
        check("queue drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
